// File: rtl/audiodac_cfg_seq.sv
// rtl/audiodac_cfg_seq.sv - click-free mode/OSR/volume sequencer for the audio DAC modulator
module audiodac_cfg_seq #(
    parameter int RAMP_SAMPLES  = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cfg_mode_i,
    input  logic [1:0] cfg_osr_i,
    input  logic [3:0] cfg_volume_i,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic       audio_rd_i,
    output logic       mod_rst_n_o,
    output logic       mod_mode_o,
    output logic [1:0] mod_osr_o,
    output logic [3:0] mod_volume_o,
    output logic       busy_o
);

    localparam logic [7:0] RAMP_LAST   = 8'(RAMP_SAMPLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {INIT, IDLE, RAMP, RAMP_DN, HOLD, RAMP_UP} state_t;

    state_t     state, state_n;
    logic       tgt_mode;
    logic [1:0] tgt_osr;
    logic [3:0] tgt_vol;
    logic [7:0] scnt;
    logic [7:0] hcnt;

    logic       xfer;
    logic       in_ramp;
    logic [3:0] goal;
    logic       step;

    assign xfer    = cfg_valid_i && cfg_ready_o;
    assign in_ramp = (state == RAMP) || (state == RAMP_DN) || (state == RAMP_UP);
    assign goal    = (state == RAMP_DN) ? 4'd0 : tgt_vol;
    // A volume step lands on the pulse that completes RAMP_SAMPLES samples.
    assign step    = in_ramp && audio_rd_i && (scnt == RAMP_LAST);

    always_comb begin
        state_n = state;
        case (state)
            INIT:    if (mod_rst_n_o) state_n = IDLE;
            IDLE: begin
                if (xfer) begin
                    if ((cfg_mode_i != mod_mode_o) || (cfg_osr_i != mod_osr_o))
                        state_n = RAMP_DN;
                    else if (cfg_volume_i != mod_volume_o)
                        state_n = RAMP;
                end
            end
            RAMP,
            RAMP_UP: if (mod_volume_o == tgt_vol) state_n = IDLE;
            RAMP_DN: if (mod_volume_o == 4'd0) state_n = HOLD;
            HOLD:    if (hcnt == SETTLE_LAST) state_n = RAMP_UP;
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= INIT;
            tgt_mode     <= 1'b0;
            tgt_osr      <= 2'd0;
            tgt_vol      <= 4'd0;
            scnt         <= 8'd0;
            hcnt         <= 8'd0;
            cfg_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
            mod_rst_n_o  <= 1'b0;
            mod_mode_o   <= 1'b0;
            mod_osr_o    <= 2'd0;
            mod_volume_o <= 4'd0;
        end else begin
            state       <= state_n;
            cfg_ready_o <= (state_n == IDLE);
            busy_o      <= (state_n != IDLE);

            if (state_n != state)
                scnt <= 8'd0;
            else if (in_ramp && audio_rd_i)
                scnt <= step ? 8'd0 : scnt + 8'd1;

            if (step && (mod_volume_o != goal)) begin
                if (mod_volume_o < goal)
                    mod_volume_o <= mod_volume_o + 4'd1;
                else
                    mod_volume_o <= mod_volume_o - 4'd1;
            end

            case (state)
                INIT: begin
                    if (!mod_rst_n_o) begin
                        if (hcnt == SETTLE_LAST)
                            mod_rst_n_o <= 1'b1;
                        else
                            hcnt <= hcnt + 8'd1;
                    end
                end
                IDLE: begin
                    if (xfer) begin
                        tgt_mode <= cfg_mode_i;
                        tgt_osr  <= cfg_osr_i;
                        tgt_vol  <= cfg_volume_i;
                    end
                end
                RAMP_DN: begin
                    // Mode/OSR only ever change while the modulator goes into reset.
                    if (state_n == HOLD) begin
                        mod_rst_n_o <= 1'b0;
                        mod_mode_o  <= tgt_mode;
                        mod_osr_o   <= tgt_osr;
                        hcnt        <= 8'd0;
                    end
                end
                HOLD: begin
                    hcnt <= hcnt + 8'd1;
                    if (state_n == RAMP_UP)
                        mod_rst_n_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audiodac_cfg_seq.sv
// tb/tb_audiodac_cfg_seq.sv - directed self-checking bench with volume-step scoreboard
module tb_audiodac_cfg_seq;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       cfg_mode_i = 1'b0;
    logic [1:0] cfg_osr_i = 2'd0;
    logic [3:0] cfg_volume_i = 4'd0;
    logic       cfg_valid_i = 1'b0;
    logic       cfg_ready_o;
    logic       audio_rd_i = 1'b0;
    logic       mod_rst_n_o;
    logic       mod_mode_o;
    logic [1:0] mod_osr_o;
    logic [3:0] mod_volume_o;
    logic       busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    int         exp_q[$];
    logic [3:0] prev_vol = 4'd0;

    int m_mode = 0;
    int m_osr  = 0;
    int m_vol  = 0;

    audiodac_cfg_seq #(.RAMP_SAMPLES(4), .SETTLE_CYCLES(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_mode_i   (cfg_mode_i),
        .cfg_osr_i    (cfg_osr_i),
        .cfg_volume_i (cfg_volume_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .audio_rd_i   (audio_rd_i),
        .mod_rst_n_o  (mod_rst_n_o),
        .mod_mode_o   (mod_mode_o),
        .mod_osr_o    (mod_osr_o),
        .mod_volume_o (mod_volume_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every change of the applied volume must match the next expected step.
    always @(negedge clk_i) begin
        if (mod_volume_o !== prev_vol) begin
            logic [7:0] e;
            e = (exp_q.size() != 0) ? 8'(exp_q.pop_front()) : 8'hEE;
            check("sb_vol", {4'd0, mod_volume_o}, e);
            prev_vol = mod_volume_o;
        end
    end

    task automatic push_path(input int mode, input int osr, input int vol);
        if (mode != m_mode || osr != m_osr) begin
            for (int v = m_vol - 1; v >= 0; v--) exp_q.push_back(v);
            for (int v = 1; v <= vol; v++) exp_q.push_back(v);
        end else if (vol > m_vol) begin
            for (int v = m_vol + 1; v <= vol; v++) exp_q.push_back(v);
        end else begin
            for (int v = m_vol - 1; v >= vol; v--) exp_q.push_back(v);
        end
        m_mode = mode; m_osr = osr; m_vol = vol;
    endtask

    // Returns at the falling edge just after the transfer edge.
    task automatic send(input int mode, input int osr, input int vol);
        int c;
        c = 0;
        cfg_mode_i   = 1'(mode);
        cfg_osr_i    = 2'(osr);
        cfg_volume_i = 4'(vol);
        cfg_valid_i  = 1'b1;
        while (cfg_ready_o !== 1'b1 && c < 2000) begin
            @(negedge clk_i);
            c++;
        end
        check("send_ready", {7'd0, cfg_ready_o}, 8'd1);
        push_path(mode, osr, vol);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
    endtask

    task automatic run_idle(input int gap, input string tag);
        int c;
        c = 0;
        while (busy_o !== 1'b0 && c < 3000) begin
            audio_rd_i = ((c % gap) == 0);
            @(negedge clk_i);
            c++;
        end
        audio_rd_i = 1'b0;
        check(tag, {7'd0, busy_o}, 8'd0);
    endtask

    task automatic pulse();
        audio_rd_i = 1'b1;
        @(negedge clk_i);
        audio_rd_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rstn"},  {7'd0, mod_rst_n_o}, 8'd0);
        check({tag, "_mode"},  {7'd0, mod_mode_o}, 8'd0);
        check({tag, "_osr"},   {6'd0, mod_osr_o}, 8'd0);
        check({tag, "_vol"},   {4'd0, mod_volume_o}, 8'd0);
        check({tag, "_ready"}, {7'd0, cfg_ready_o}, 8'd0);
        check({tag, "_busy"},  {7'd0, busy_o}, 8'd1);
    endtask

    // Called at a falling edge; releases reset and follows the startup hold.
    task automatic init_seq(input string tag);
        int bad;
        bad = 0;
        rst_i = 1'b0;
        repeat (15) begin
            @(negedge clk_i);
            if (mod_rst_n_o !== 1'b0 || cfg_ready_o !== 1'b0) bad++;
        end
        check({tag, "_hold_low"}, 8'(bad), 8'd0);
        @(negedge clk_i);
        check({tag, "_rstn_up"}, {7'd0, mod_rst_n_o}, 8'd1);
        check({tag, "_ready_lag"}, {7'd0, cfg_ready_o}, 8'd0);
        @(negedge clk_i);
        check({tag, "_ready"}, {7'd0, cfg_ready_o}, 8'd1);
        check({tag, "_busy"}, {7'd0, busy_o}, 8'd0);
    endtask

    initial begin
        int bad, low_cnt, c;

        // Asynchronous reset before any clock edge.
        #2 rst_i = 1'b1;
        #1 check_reset_vals("por");
        @(negedge clk_i);
        init_seq("init");

        // Volume up 0 -> 3, one pulse every 32 clocks.
        send(0, 0, 3);
        bad = 0;
        for (int p = 1; p <= 12; p++) begin
            repeat (31) @(negedge clk_i);
            pulse();
            check("volup_step", {4'd0, mod_volume_o}, 8'(p / 4));
            if (mod_rst_n_o !== 1'b1) bad++;
        end
        check("volup_rstn", 8'(bad), 8'd0);
        check("volup_busy_last", {7'd0, busy_o}, 8'd1);
        @(negedge clk_i);
        check("volup_idle", {7'd0, busy_o}, 8'd0);
        check("volup_ready", {7'd0, cfg_ready_o}, 8'd1);

        // Mode change with continuous sample strobes.
        send(1, 0, 2);
        bad = 0;
        low_cnt = 0;
        c = 0;
        audio_rd_i = 1'b1;
        while (busy_o !== 1'b0 && c < 500) begin
            @(negedge clk_i);
            c++;
            if (mod_rst_n_o === 1'b0) begin
                low_cnt++;
                if (mod_mode_o !== 1'b1 || mod_volume_o !== 4'd0) bad++;
            end else if (mod_mode_o === 1'b1 && low_cnt == 0) begin
                bad++;
            end
        end
        audio_rd_i = 1'b0;
        check("mode_done", {7'd0, busy_o}, 8'd0);
        check("mode_hold_len", 8'(low_cnt), 8'd16);
        check("mode_hold_ok", 8'(bad), 8'd0);
        check("mode_vol", {4'd0, mod_volume_o}, 8'd2);
        check("mode_mode", {7'd0, mod_mode_o}, 8'd1);

        // Backpressure: request held during a ramp is taken on the first ready cycle.
        send(1, 0, 4);
        cfg_volume_i = 4'd5;
        cfg_valid_i  = 1'b1;
        c = 0;
        while (cfg_ready_o !== 1'b1 && c < 500) begin
            audio_rd_i = ((c % 3) == 0);
            @(negedge clk_i);
            c++;
        end
        audio_rd_i = 1'b0;
        check("bp_ready", {7'd0, cfg_ready_o}, 8'd1);
        check("bp_vol_before", {4'd0, mod_volume_o}, 8'd4);
        push_path(1, 0, 5);
        @(negedge clk_i);
        check("bp_taken_ready", {7'd0, cfg_ready_o}, 8'd0);
        check("bp_taken_busy", {7'd0, busy_o}, 8'd1);
        cfg_valid_i  = 1'b0;
        cfg_volume_i = 4'd9;
        run_idle(3, "bp_done");
        check("bp_vol", {4'd0, mod_volume_o}, 8'd5);

        // Unchanged request is a no-op.
        send(1, 0, 5);
        check("noop_ready", {7'd0, cfg_ready_o}, 8'd1);
        check("noop_busy", {7'd0, busy_o}, 8'd0);

        // Ramp to full scale; further strobes in IDLE do nothing.
        send(1, 0, 15);
        run_idle(1, "max_done");
        check("max_vol", {4'd0, mod_volume_o}, 8'd15);
        audio_rd_i = 1'b1;
        repeat (8) @(negedge clk_i);
        audio_rd_i = 1'b0;
        check("max_nowrap", {4'd0, mod_volume_o}, 8'd15);
        check("max_idle", {7'd0, busy_o}, 8'd0);

        // Down to 0, then an OSR/mode change enters HOLD on the next edge.
        send(1, 0, 0);
        run_idle(1, "zero_done");
        check("zero_vol", {4'd0, mod_volume_o}, 8'd0);
        send(0, 1, 0);
        check("dn0_rstn_pre", {7'd0, mod_rst_n_o}, 8'd1);
        @(negedge clk_i);
        check("dn0_rstn", {7'd0, mod_rst_n_o}, 8'd0);
        check("dn0_osr", {6'd0, mod_osr_o}, 8'd1);
        check("dn0_mode", {7'd0, mod_mode_o}, 8'd0);

        // Reset in the middle of HOLD.
        repeat (5) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_reset_vals("hold_rst");
        m_mode = 0; m_osr = 0; m_vol = 0;
        @(negedge clk_i);
        init_seq("reinit");

        check("sb_empty", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
